sensor_frame_rx: RTL and testbench

- Serial receiver for the four altimeter sensor bytes that feed the height-estimation path.
- The sensor hub transmits each sample as one framed byte stream: SYNC byte, then 4 data bytes (sensor1..sensor4), then an XOR checksum byte.
- This block hunts for SYNC, deserializes the frame, checks the checksum and updates the parallel sensor1..sensor4 registers only on a good frame.
- The outputs drive the sensor inputs of baggage_drop directly.

---
 rtl/baggage_drop_pkg.sv | 20 ++
 rtl/ser_byte_shift.sv | 46 ++++
 rtl/sensor_frame_rx.sv | 158 +++++++++++++++
 tb/tb_sensor_frame_rx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/baggage_drop_pkg.sv
// ============================================================================
// baggage_drop_pkg : shared types/constants for the sensor frame receiver
// Rev 1.0
// ============================================================================
`default_nettype none

package baggage_drop_pkg;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_DATA = 2'd1,
        ST_CSUM = 2'd2
    } rx_state_e;

    localparam int         FRAME_DATA_BYTES  = 4;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

`default_nettype wire

// File: rtl/ser_byte_shift.sv
// ============================================================================
// ser_byte_shift : 8-bit MSB-first shifter with saturating bit counter
// Rev 1.0
// ============================================================================
`default_nettype none

module ser_byte_shift (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       shift_en,
    input  logic       clr,
    input  logic       bit_in,
    output logic [7:0] byte_nxt,
    output logic       byte_done
);

    logic [7:0] win_q, win_d;
    logic [3:0] cnt_q, cnt_d;

    // byte_nxt/byte_done look at the bit being shifted this cycle, so the
    // owner can act on a completed byte at the same edge that samples it.
    always_comb begin
        byte_nxt  = {win_q[6:0], bit_in};
        byte_done = shift_en && (cnt_q >= 4'd7);
        win_d     = shift_en ? byte_nxt : win_q;
        cnt_d     = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (shift_en && (cnt_q != 4'd8)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= 8'd0;
            cnt_q <= 4'd0;
        end else begin
            win_q <= win_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sensor_frame_rx.sv
// ============================================================================
// sensor_frame_rx : SYNC-hunting serial receiver for four altimeter bytes
// Rev 1.0
// ============================================================================
`default_nettype none

module sensor_frame_rx
    import baggage_drop_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_in,
    input  logic       ser_valid,
    output logic [7:0] sensor1,
    output logic [7:0] sensor2,
    output logic [7:0] sensor3,
    output logic [7:0] sensor4,
    output logic       data_valid,
    output logic       frame_ok,
    output logic       frame_err
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [1:0] LAST_IDX = 2'(FRAME_DATA_BYTES - 1);

    rx_state_e                              state_q, state_d;
    logic [FRAME_DATA_BYTES-1:0][7:0]       stage_q, stage_d;
    logic [FRAME_DATA_BYTES-1:0][7:0]       sensor_q, sensor_d;
    logic [7:0]                             csum_q, csum_d;
    logic [1:0]                             byte_idx_q, byte_idx_d;
    logic [IDLE_W-1:0]                      idle_q, idle_d;
    logic                                   pend_ok_q, pend_ok_d;
    logic                                   pend_err_q, pend_err_d;
    logic                                   data_valid_q, data_valid_d;
    logic                                   frame_ok_q, frame_ok_d;
    logic                                   frame_err_q, frame_err_d;

    logic       shf_clr;
    logic [7:0] byte_nxt;
    logic       byte_done;

    ser_byte_shift u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  (ser_valid),
        .clr       (shf_clr),
        .bit_in    (ser_in),
        .byte_nxt  (byte_nxt),
        .byte_done (byte_done)
    );

    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        sensor_d     = sensor_q;
        csum_d       = csum_q;
        byte_idx_d   = byte_idx_q;
        idle_d       = idle_q;
        data_valid_d = data_valid_q;
        pend_ok_d    = 1'b0;
        pend_err_d   = 1'b0;
        shf_clr      = 1'b0;

        // Verdicts are held one cycle so the publish edge trails the sampling edge.
        frame_ok_d  = pend_ok_q;
        frame_err_d = pend_err_q;
        if (pend_ok_q) begin
            sensor_d     = stage_q;
            data_valid_d = 1'b1;
        end

        case (state_q)
            ST_HUNT: begin
                idle_d = '0;
                if (byte_done && (byte_nxt == SYNC_BYTE)) begin
                    state_d    = ST_DATA;
                    byte_idx_d = 2'd0;
                    csum_d     = 8'd0;
                    shf_clr    = 1'b1;
                end
            end
            ST_DATA, ST_CSUM: begin
                if (ser_valid) begin
                    idle_d = '0;
                    if (byte_done) begin
                        shf_clr = 1'b1;
                        if (state_q == ST_DATA) begin
                            stage_d[byte_idx_q] = byte_nxt;
                            csum_d              = csum_q ^ byte_nxt;
                            byte_idx_d          = byte_idx_q + 2'd1;
                            if (byte_idx_q == LAST_IDX) begin
                                state_d = ST_CSUM;
                            end
                        end else begin
                            pend_ok_d  = (byte_nxt == csum_q);
                            pend_err_d = (byte_nxt != csum_q);
                            state_d    = ST_HUNT;
                        end
                    end
                end else if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
                    pend_err_d = 1'b1;
                    state_d    = ST_HUNT;
                    stage_d    = '0;
                    idle_d     = '0;
                    shf_clr    = 1'b1;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            default: begin
                state_d = ST_HUNT;
                shf_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HUNT;
            stage_q      <= '0;
            sensor_q     <= '0;
            csum_q       <= 8'd0;
            byte_idx_q   <= 2'd0;
            idle_q       <= '0;
            pend_ok_q    <= 1'b0;
            pend_err_q   <= 1'b0;
            data_valid_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            sensor_q     <= sensor_d;
            csum_q       <= csum_d;
            byte_idx_q   <= byte_idx_d;
            idle_q       <= idle_d;
            pend_ok_q    <= pend_ok_d;
            pend_err_q   <= pend_err_d;
            data_valid_q <= data_valid_d;
            frame_ok_q   <= frame_ok_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign sensor1    = sensor_q[0];
    assign sensor2    = sensor_q[1];
    assign sensor3    = sensor_q[2];
    assign sensor4    = sensor_q[3];
    assign data_valid = data_valid_q;
    assign frame_ok   = frame_ok_q;
    assign frame_err  = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_sensor_frame_rx.sv
// ============================================================================
// tb_sensor_frame_rx : directed self-checking bench for sensor_frame_rx
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sensor_frame_rx;

    localparam int T = 1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ser_in;
    logic       ser_valid;
    logic [7:0] sensor1, sensor2, sensor3, sensor4;
    logic       data_valid, frame_ok, frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    int ok_cnt   = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int o0, e0;

    sensor_frame_rx #(
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .sensor1    (sensor1),
        .sensor2    (sensor2),
        .sensor3    (sensor3),
        .sensor4    (sensor4),
        .data_valid (data_valid),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse counters read the settled pre-edge values.
    always @(posedge clk) begin
        if (frame_ok)              ok_cnt++;
        if (frame_err)             err_cnt++;
        if (frame_ok && frame_err) both_cnt++;
    end

    function automatic logic [31:0] sens();
        return {sensor1, sensor2, sensor3, sensor4};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic send_bit(input logic b);
        ser_in    = b;
        ser_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic idle_n(input int n);
        ser_valid = 1'b0;
        ser_in    = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4,
                              input logic [7:0] cs);
        send_byte(8'hA5);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        send_byte(b4);
        send_byte(cs);
    endtask

    // Called right after the checksum's last bit has been sampled.
    task automatic expect_good(input string tag, input logic [31:0] old_s, input logic [31:0] new_s);
        ser_valid = 1'b0;
        check_val({tag, "_pre_ok"}, {31'd0, frame_ok}, 32'd0);
        check_val({tag, "_pre_sens"}, sens(), old_s);
        @(negedge clk);
        check_val({tag, "_ok"}, {31'd0, frame_ok}, 32'd1);
        check_val({tag, "_err"}, {31'd0, frame_err}, 32'd0);
        check_val({tag, "_sens"}, sens(), new_s);
        check_val({tag, "_dv"}, {31'd0, data_valid}, 32'd1);
        @(negedge clk);
        check_val({tag, "_ok_drop"}, {31'd0, frame_ok}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        ser_valid = 1'b0;
        ser_in    = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_sens", sens(), 32'h0);
        check_val("rst_dv", {31'd0, data_valid}, 32'd0);
        check_val("rst_ok", {31'd0, frame_ok}, 32'd0);
        check_val("rst_err", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Good frame
        send_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'h40);
        expect_good("good", 32'h0, 32'h10203040);
        idle_n(2);

        // Bad checksum: 11^22^33^44 = 44, sent 00
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h00);
        ser_valid = 1'b0;
        check_val("bad_pre_err", {31'd0, frame_err}, 32'd0);
        @(negedge clk);
        check_val("bad_err", {31'd0, frame_err}, 32'd1);
        check_val("bad_ok", {31'd0, frame_ok}, 32'd0);
        check_val("bad_sens", sens(), 32'h10203040);
        check_val("bad_dv", {31'd0, data_valid}, 32'd1);
        @(negedge clk);
        check_val("bad_err_drop", {31'd0, frame_err}, 32'd0);
        idle_n(2);

        // Junk bits before SYNC
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
        expect_good("hunt", 32'h10203040, 32'h01020304);
        idle_n(2);

        // Checksum 01 leaves a trailing 1 in the window; 7 fresh bits must not complete A5
        send_frame(8'h00, 8'h00, 8'h00, 8'h01, 8'h01);
        expect_good("pre_stale", 32'h01020304, 32'h00000001);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        idle_n(3);
        send_frame(8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h00);
        expect_good("stale", 32'h00000001, 32'h0A0B0C0D);
        idle_n(2);

        // Timeout after partial frame
        o0 = ok_cnt; e0 = err_cnt;
        send_byte(8'hA5);
        send_byte(8'h55);
        idle_n(T + 10);
        check_val("to_err_cnt", err_cnt - e0, 32'd1);
        check_val("to_ok_cnt", ok_cnt - o0, 32'd0);
        check_val("to_sens", sens(), 32'h0A0B0C0D);
        check_val("to_dv", {31'd0, data_valid}, 32'd1);

        // Gap of T-1 idle cycles is tolerated: 55^66^77^88 = CC
        e0 = err_cnt;
        send_byte(8'hA5);
        send_byte(8'h55);
        idle_n(T - 1);
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h88);
        send_byte(8'hCC);
        expect_good("gap", 32'h0A0B0C0D, 32'h55667788);
        idle_n(3);
        check_val("gap_err_cnt", err_cnt - e0, 32'd0);

        // Back-to-back frames with zero gap
        o0 = ok_cnt; e0 = err_cnt;
        send_frame(8'h01, 8'h01, 8'h01, 8'h01, 8'h00);
        send_frame(8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00);
        idle_n(5);
        check_val("b2b_ok_cnt", ok_cnt - o0, 32'd2);
        check_val("b2b_err_cnt", err_cnt - e0, 32'd0);
        check_val("b2b_sens", sens(), 32'hFF00FF00);

        // Reset during byte 2
        send_byte(8'hA5);
        send_byte(8'h12);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        ser_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_val("mid_rst_sens", sens(), 32'h0);
        check_val("mid_rst_dv", {31'd0, data_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(8'h21, 8'h22, 8'h23, 8'h24, 8'h04);
        expect_good("post_rst", 32'h0, 32'h21222324);
        idle_n(2);

        check_val("ok_err_overlap", both_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
